// File: rtl/ucnt_pkg.sv
// Shared definitions for the parametrised universal counter: mode encodings
// and a couple of helpers for decoding them.
package ucnt_pkg;

    localparam logic [1:0] UC_BIN_WRAP = 2'b00;
    localparam logic [1:0] UC_MOD_WRAP = 2'b01;
    localparam logic [1:0] UC_BIN_SAT  = 2'b10;
    localparam logic [1:0] UC_MOD_SAT  = 2'b11;

    function automatic logic uc_is_modulo(input logic [1:0] mode);
        return (mode == UC_MOD_WRAP) || (mode == UC_MOD_SAT);
    endfunction

    function automatic logic uc_is_saturate(input logic [1:0] mode);
        return (mode == UC_BIN_SAT) || (mode == UC_MOD_SAT);
    endfunction

endpackage

// File: rtl/ucnt_next.sv
// Combinational next-state step of the universal counter: computes the
// stepped value, whether that step wraps, and whether count sits at terminal.
module ucnt_next
    import ucnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] count,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             incr,
    output logic [WIDTH-1:0] next_count,
    output logic             wrap_evt,
    output logic             at_term
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic             is_mod;
    logic             is_sat;
    logic [WIDTH-1:0] top_val;

    assign is_mod = uc_is_modulo(mode);
    assign is_sat = uc_is_saturate(mode);

    // A modulus of zero stands for the full 2^WIDTH range.
    assign top_val = (is_mod && (mod_val != '0)) ? (mod_val - ONE) : '1;

    always_comb begin
        next_count = count;
        wrap_evt   = 1'b0;
        if (incr) begin
            if (count >= top_val) begin
                if (!is_sat) begin
                    next_count = '0;
                    wrap_evt   = 1'b1;
                end
            end else begin
                next_count = count + ONE;
            end
        end else begin
            if (count == '0) begin
                if (!is_sat) begin
                    next_count = top_val;
                    wrap_evt   = 1'b1;
                end
            end else if (count > top_val) begin
                // Out-of-range value (after load or modulus change) snaps to top.
                next_count = top_val;
            end else begin
                next_count = count - ONE;
            end
        end
    end

    assign at_term = incr ? (count >= top_val) : (count == '0);

endmodule

// File: rtl/universal_counter_param.sv
// WIDTH-bit universal counter: clear > load > pause > count priority, with a
// combinational terminal-count flag and a registered wrap pulse for cascading.
module universal_counter_param
    import ucnt_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] mod_val,
    input  logic             incr,
    input  logic             pause,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] step_count;
    logic             step_wrap;
    logic             at_term;

    ucnt_next #(
        .WIDTH(WIDTH)
    ) u_next (
        .count      (count_q),
        .mode       (mode),
        .mod_val    (mod_val),
        .incr       (incr),
        .next_count (step_count),
        .wrap_evt   (step_wrap),
        .at_term    (at_term)
    );

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_val;
        end else if (!pause) begin
            count_d = step_count;
            wrap_d  = step_wrap;
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            count_q <= RESET_VAL;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign wrap  = wrap_q;
    assign tc    = !pause && !clear && !load && at_term;

endmodule

// File: tb/tb_universal_counter_param.sv
// Scoreboard bench for universal_counter_param at WIDTH=4: the driver queues
// hand-computed post-edge expectations, a monitor pops and compares them.
module tb_universal_counter_param;

    localparam int W = 4;

    logic         clk;
    logic         clear_n;
    logic         clear;
    logic         load;
    logic [W-1:0] load_val;
    logic [1:0]   mode;
    logic [W-1:0] mod_val;
    logic         incr;
    logic         pause;
    logic [W-1:0] count;
    logic         tc;
    logic         wrap;

    universal_counter_param #(
        .WIDTH     (W),
        .RESET_VAL (4'd0)
    ) dut (
        .clk      (clk),
        .clear_n  (clear_n),
        .clear    (clear),
        .load     (load),
        .load_val (load_val),
        .mode     (mode),
        .mod_val  (mod_val),
        .incr     (incr),
        .pause    (pause),
        .count    (count),
        .tc       (tc),
        .wrap     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [W-1:0] cnt;
        logic         wrp;
        logic         tcv;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    event chk_ev;

    task automatic cmp(input string what, input string nm, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s.%s: got %0d, expected %0d (t=%0t)", nm, what, act, req, $time);
        end
    endtask

    // Monitor: the counter presents a new output after each edge (or at once
    // on async reset); compare against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cmp("count", e.name, int'(count), int'(e.cnt));
                cmp("wrap",  e.name, int'(wrap),  int'(e.wrp));
                cmp("tc",    e.name, int'(tc),    int'(e.tcv));
                $display("txn %-10s count=%0d wrap=%0b tc=%0b", e.name, count, wrap, tc);
            end
        end
    end

    task automatic step(input string nm, input logic c, input logic l, input logic [W-1:0] lv,
                        input logic [1:0] md, input logic [W-1:0] mv, input logic inc,
                        input logic ps, input logic [W-1:0] ec, input logic ew, input logic et);
        exp_t e;
        clear    = c;
        load     = l;
        load_val = lv;
        mode     = md;
        mod_val  = mv;
        incr     = inc;
        pause    = ps;
        e.name = nm; e.cnt = ec; e.wrp = ew; e.tcv = et;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        clear_n = 1'b0; clear = 1'b0; load = 1'b0; load_val = '0;
        mode = 2'b00; mod_val = '0; incr = 1'b1; pause = 1'b0;
        @(negedge clk);
        e.name = "rst_state"; e.cnt = 4'd0; e.wrp = 1'b0; e.tcv = 1'b0;
        exp_q.push_back(e);
        ->chk_ev;
        @(negedge clk);
        clear_n = 1'b1;

        // Async reset mid-cycle with count=9
        step("ld9", 0, 1, 4'd9, 2'b00, 4'd0, 1, 0, 4'd9, 0, 0);
        clear_n = 1'b0; load = 1'b0;
        e.name = "async_rst"; e.cnt = 4'd0; e.wrp = 1'b0; e.tcv = 1'b0;
        exp_q.push_back(e);
        ->chk_ev;
        @(negedge clk);
        clear_n = 1'b1;

        // Binary wrap up: 1..15 then 0 with wrap
        for (int i = 1; i <= 15; i++)
            step("bin_up", 0, 0, 4'd0, 2'b00, 4'd0, 1, 0, 4'(i), 0, (i == 15));
        step("bin_wrap", 0, 0, 4'd0, 2'b00, 4'd0, 1, 0, 4'd0, 1, 0);

        // Modulo-10 up, wrap at 9->0, then down wrap 0->9
        for (int i = 1; i <= 9; i++)
            step("mod10_up", 0, 0, 4'd0, 2'b01, 4'd10, 1, 0, 4'(i), 0, (i == 9));
        step("mod10_wrap", 0, 0, 4'd0, 2'b01, 4'd10, 1, 0, 4'd0, 1, 0);
        step("mod10_dnw", 0, 0, 4'd0, 2'b01, 4'd10, 0, 0, 4'd9, 1, 0);
        step("ld13", 0, 1, 4'd13, 2'b01, 4'd10, 0, 0, 4'd13, 0, 0);
        step("dn_snap", 0, 0, 4'd0, 2'b01, 4'd10, 0, 0, 4'd9, 0, 0);

        // Binary saturate up and down
        step("ld14", 0, 1, 4'd14, 2'b10, 4'd0, 1, 0, 4'd14, 0, 0);
        step("sat_up", 0, 0, 4'd0, 2'b10, 4'd0, 1, 0, 4'd15, 0, 1);
        for (int i = 0; i < 3; i++)
            step("sat_hold", 0, 0, 4'd0, 2'b10, 4'd0, 1, 0, 4'd15, 0, 1);
        step("ld1", 0, 1, 4'd1, 2'b10, 4'd0, 0, 0, 4'd1, 0, 0);
        step("sat_dn", 0, 0, 4'd0, 2'b10, 4'd0, 0, 0, 4'd0, 0, 1);
        for (int i = 0; i < 2; i++)
            step("sat_dnhold", 0, 0, 4'd0, 2'b10, 4'd0, 0, 0, 4'd0, 0, 1);

        // Pause, then clear/load/pause together
        step("ld5", 0, 1, 4'd5, 2'b00, 4'd0, 1, 0, 4'd5, 0, 0);
        for (int i = 0; i < 3; i++)
            step("pause", 0, 0, 4'd0, 2'b00, 4'd0, 1, 1, 4'd5, 0, 0);
        step("clr_prio", 1, 1, 4'd7, 2'b00, 4'd0, 1, 1, 4'd0, 0, 0);
        step("ld15", 0, 1, 4'd15, 2'b00, 4'd0, 1, 0, 4'd15, 0, 0);
        step("pause_tc", 0, 0, 4'd0, 2'b00, 4'd0, 1, 1, 4'd15, 0, 0);
        step("clr", 1, 0, 4'd0, 2'b00, 4'd0, 1, 0, 4'd0, 0, 0);

        // mod_val=0 behaves as mod-16; mod_val=1 keeps count at 0
        for (int i = 1; i <= 15; i++)
            step("mod0_up", 0, 0, 4'd0, 2'b01, 4'd0, 1, 0, 4'(i), 0, (i == 15));
        step("mod0_wrap", 0, 0, 4'd0, 2'b01, 4'd0, 1, 0, 4'd0, 1, 0);
        for (int i = 0; i < 3; i++)
            step("mod1_wrap", 0, 0, 4'd0, 2'b01, 4'd1, 1, 0, 4'd0, 1, 1);
        step("mod1_sat", 0, 0, 4'd0, 2'b11, 4'd1, 1, 0, 4'd0, 0, 1);

        // Modulus shrink below count, then binary down wrap
        step("ld7", 0, 1, 4'd7, 2'b01, 4'd10, 1, 0, 4'd7, 0, 0);
        step("mod_shrink", 0, 0, 4'd0, 2'b01, 4'd4, 1, 0, 4'd0, 1, 0);
        step("bin_dnwrap", 0, 0, 4'd0, 2'b00, 4'd0, 0, 0, 4'd15, 1, 0);

        // Modulo saturate, down from out-of-range snaps to top without wrap
        step("ld15b", 0, 1, 4'd15, 2'b11, 4'd5, 0, 0, 4'd15, 0, 0);
        step("msat_snap", 0, 0, 4'd0, 2'b11, 4'd5, 0, 0, 4'd4, 0, 0);
        step("msat_dn", 0, 0, 4'd0, 2'b11, 4'd5, 0, 0, 4'd3, 0, 0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/universal_counter_param.md
Name: universal_counter_param

Overview:
- Parametrised successor to the 4-bit universal counter.
- Counter of WIDTH bits with:
  - up/down direction
  - pause
  - synchronous clear
  - parallel load
  - runtime-programmable modulus
  - four counting modes: binary wrap, modulo-N wrap, binary saturate, modulo-N saturate
- Outputs a combinational terminal-count flag and a registered wrap pulse, so instances can cascade into wider counters or timers.

Parameters:
- WIDTH, 8, counter width in bits (>= 2).
- RESET_VAL, 0, value of count after async reset (must be < 2^WIDTH).

Ports:
- clk  in  1  rising-edge clock.
- clear_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear, active-high.
- load  in  1  synchronous parallel load, active-high.
- load_val  in  WIDTH  value loaded when load=1.
- mode  in  2  00 binary wrap, 01 modulo-N wrap, 10 binary saturate, 11 modulo-N saturate.
- mod_val  in  WIDTH  modulus N for modes 01/11; 0 means 2^WIDTH.
- incr  in  1  1 = count up, 0 = count down.
- pause  in  1  1 = hold count.
- count  out  WIDTH  current count, registered.
- tc  out  1  combinational; count is at the terminal value for the current direction/mode and pause=0.
- wrap  out  1  registered one-cycle pulse; previous edge wrapped around.

Behaviour:
- Reset: clear_n=0 forces count=RESET_VAL and wrap=0 immediately, independent of clk. Deassertion is synchronised by the system.
- Per-edge priority: clear > load > pause > count.
  - clear: count=0, wrap=0.
  - load: count=load_val, wrap=0.
  - pause: count holds, wrap=0.
  - otherwise step by ±1 per mode.
- Top value T:
  - modes 00/10: T = 2^WIDTH-1.
  - modes 01/11: T = mod_val-1, or 2^WIDTH-1 when mod_val=0.
- Up, count<T: count+1.
- Up, count>=T:
  - wrap modes: count=0, wrap=1.
  - saturate modes: count holds, wrap=0.
- Down, count=0:
  - wrap modes: count=T, wrap=1.
  - saturate modes: hold.
- Down, count>T (modulo modes only, e.g. after load or mod_val change): count=T, wrap=0.
- Up, count>T: treated as count>=T (wraps to 0 / holds). No value above T is ever produced by counting.
- mod_val=1: T=0.
  - Wrap mode: count stays 0 and wrap pulses every enabled edge.
  - Saturate mode: count stays 0, no pulse.
- tc = !pause && !clear && !load && ((incr && count>=T) || (!incr && count==0)).
- Changes to mode, mod_val and incr are sampled at each edge and take effect on that edge. No pipeline.
- Latency: count updates one cycle after the controlling inputs. wrap is asserted in the same cycle that count shows the wrapped value.
- All arithmetic is WIDTH bits, unsigned. There is no overflow beyond the wrap and saturate rules.

Decomposition:
- ucnt_pkg: mode encodings as named constants (UC_BIN_WRAP, UC_MOD_WRAP, UC_BIN_SAT, UC_MOD_SAT).
- One combinational sub-module, ucnt_next:
  - inputs: count, mode, mod_val, incr.
  - outputs: next_count, wrap_evt, at_term.
  - this sub-module is reused by the tc logic.
- Top level holds the register, the priority mux and the wrap flop.

Test Plan (WIDTH=4):
- clear_n low mid-cycle with count=9 -> count=0 immediately, wrap=0. Release, mode=00, incr=1 for 16 edges -> 0..15, then 0 with wrap=1 on that edge; tc=1 while count=15.
- mode=01, mod_val=10, incr=1 -> 0..9,0 with wrap pulse at 9->0. incr=0 from 0 -> 9 with wrap=1. Then load_val=13 followed by incr=0 -> 9 with no wrap.
- mode=10, incr=1 from 14 -> 15 and holds for 3 edges with wrap=0 and tc=1. Same mode, incr=0 from 1 -> 0 and holds.
- pause=1 for 3 edges at count=5 -> count stays 5, tc=0. Assert clear, load and pause on the same edge with load_val=7 -> count=0.
- mode=01, mod_val=0 -> behaves as mod-16. mod_val=1 -> count stays 0, wrap pulses every edge.
- mod_val changed 10->4 while count=7, incr=1 -> next edge count=0 with wrap=1.
